// File: rtl/periph_xbar_ot_if.sv
// Bus bundle for periph_xbar_ot: input-side request/response ports and output-side
// slave ports. The crossbar uses modport slave, the environment uses modport master.
interface periph_xbar_ot_if #(
    parameter int N_INP      = 9,
    parameter int N_OUP      = 10,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = 4
);
    localparam int IDW  = (N_INP > 1) ? $clog2(N_INP) : 1;
    localparam int SELW = (N_OUP > 1) ? $clog2(N_OUP) : 1;

    logic [N_INP-1:0]            inp_req_i;
    logic [N_INP*SELW-1:0]       inp_sel_i;
    logic [N_INP*ADDR_WIDTH-1:0] inp_add_i;
    logic [N_INP*DATA_WIDTH-1:0] inp_wdata_i;
    logic [N_INP-1:0]            inp_wen_i;
    logic [N_INP*BE_WIDTH-1:0]   inp_be_i;
    logic [N_INP-1:0]            inp_gnt_o;
    logic [N_INP-1:0]            inp_r_valid_o;
    logic [N_INP*DATA_WIDTH-1:0] inp_r_rdata_o;
    logic [N_INP-1:0]            inp_r_opc_o;

    logic [N_OUP-1:0]            oup_req_o;
    logic [N_OUP-1:0]            oup_gnt_i;
    logic [N_OUP*ADDR_WIDTH-1:0] oup_add_o;
    logic [N_OUP*DATA_WIDTH-1:0] oup_wdata_o;
    logic [N_OUP-1:0]            oup_wen_o;
    logic [N_OUP*BE_WIDTH-1:0]   oup_be_o;
    logic [N_OUP*IDW-1:0]        oup_id_o;
    logic [N_OUP-1:0]            oup_r_valid_i;
    logic [N_OUP*IDW-1:0]        oup_r_id_i;
    logic [N_OUP*DATA_WIDTH-1:0] oup_r_rdata_i;
    logic [N_OUP-1:0]            oup_r_opc_i;

    logic                        resp_collision_o;

    modport slave (
        input  inp_req_i, inp_sel_i, inp_add_i, inp_wdata_i, inp_wen_i, inp_be_i,
        output inp_gnt_o, inp_r_valid_o, inp_r_rdata_o, inp_r_opc_o,
        output oup_req_o, oup_add_o, oup_wdata_o, oup_wen_o, oup_be_o, oup_id_o,
        input  oup_gnt_i, oup_r_valid_i, oup_r_id_i, oup_r_rdata_i, oup_r_opc_i,
        output resp_collision_o
    );

    modport master (
        output inp_req_i, inp_sel_i, inp_add_i, inp_wdata_i, inp_wen_i, inp_be_i,
        input  inp_gnt_o, inp_r_valid_o, inp_r_rdata_o, inp_r_opc_o,
        input  oup_req_o, oup_add_o, oup_wdata_o, oup_wen_o, oup_be_o, oup_id_o,
        output oup_gnt_i, oup_r_valid_i, oup_r_id_i, oup_r_rdata_i, oup_r_opc_i,
        input  resp_collision_o
    );
endinterface

// File: rtl/periph_xbar_ot.sv
// Peripheral crossbar: per-output round-robin arbiters, per-input outstanding trackers.
// Define PERIPH_XBAR_REQ_CUT_EN to add a one-entry request register on every output.
module periph_xbar_ot #(
    parameter int N_INP           = 9,
    parameter int N_OUP           = 10,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BE_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input logic             clk_i,
    input logic             rst_i,
    periph_xbar_ot_if.slave bus
);
    localparam int IDW  = (N_INP > 1) ? $clog2(N_INP) : 1;
    localparam int SELW = (N_OUP > 1) ? $clog2(N_OUP) : 1;
    localparam int CW   = $clog2(MAX_OUTSTANDING + 1);

    logic [SELW-1:0]       sel      [N_INP];
    logic [N_INP-1:0]      elig;
    logic [N_INP-1:0]      acc;
    logic [N_INP-1:0]      rsp;
    logic [CW-1:0]         cnt_q    [N_INP];
    logic [CW-1:0]         cnt_d    [N_INP];
    logic [SELW-1:0]       tgt_q    [N_INP];
    logic [SELW-1:0]       tgt_d    [N_INP];
    logic [IDW-1:0]        rr_q     [N_OUP];
    logic [IDW-1:0]        rr_d     [N_OUP];
    logic [N_INP-1:0]      cand     [N_OUP];
    logic [N_OUP-1:0]      win_vld;
    logic [IDW-1:0]        win_idx  [N_OUP];
    logic [IDW-1:0]        scan_idx;
    logic [N_OUP-1:0]      take;
    logic [ADDR_WIDTH-1:0] win_add  [N_OUP];
    logic [DATA_WIDTH-1:0] win_wdata[N_OUP];
    logic [N_OUP-1:0]      win_wen;
    logic [BE_WIDTH-1:0]   win_be   [N_OUP];

    logic [N_OUP-1:0]      src_vld;
    logic [ADDR_WIDTH-1:0] src_add  [N_OUP];
    logic [DATA_WIDTH-1:0] src_wdata[N_OUP];
    logic [N_OUP-1:0]      src_wen;
    logic [BE_WIDTH-1:0]   src_be   [N_OUP];
    logic [IDW-1:0]        src_id   [N_OUP];

    // A request may join in-flight traffic only if it goes to the same target,
    // which keeps responses per input in order without reorder buffers.
    always_comb begin
        for (int i = 0; i < N_INP; i++) begin
            sel[i]  = bus.inp_sel_i[i*SELW +: SELW];
            elig[i] = !rst_i && bus.inp_req_i[i] && (int'(sel[i]) < N_OUP) &&
                      (cnt_q[i] == '0 ||
                       (tgt_q[i] == sel[i] && int'(cnt_q[i]) < MAX_OUTSTANDING));
        end
    end

    always_comb begin
        scan_idx = '0;
        for (int j = 0; j < N_OUP; j++) begin
            cand[j]    = '0;
            win_vld[j] = 1'b0;
            win_idx[j] = '0;
            for (int i = 0; i < N_INP; i++) begin
                cand[j][i] = elig[i] && (int'(sel[i]) == j);
            end
            for (int k = 0; k < N_INP; k++) begin
                scan_idx = IDW'((int'(rr_q[j]) + k) % N_INP);
                if (!win_vld[j] && cand[j][scan_idx]) begin
                    win_vld[j] = 1'b1;
                    win_idx[j] = scan_idx;
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < N_OUP; j++) begin
            win_add[j]   = bus.inp_add_i[int'(win_idx[j])*ADDR_WIDTH +: ADDR_WIDTH];
            win_wdata[j] = bus.inp_wdata_i[int'(win_idx[j])*DATA_WIDTH +: DATA_WIDTH];
            win_wen[j]   = bus.inp_wen_i[win_idx[j]];
            win_be[j]    = bus.inp_be_i[int'(win_idx[j])*BE_WIDTH +: BE_WIDTH];
        end
    end

`ifdef PERIPH_XBAR_REQ_CUT_EN
    logic [N_OUP-1:0]      ovld_q, ovld_d;
    logic [ADDR_WIDTH-1:0] oadd_q   [N_OUP];
    logic [ADDR_WIDTH-1:0] oadd_d   [N_OUP];
    logic [DATA_WIDTH-1:0] owdata_q [N_OUP];
    logic [DATA_WIDTH-1:0] owdata_d [N_OUP];
    logic [N_OUP-1:0]      owen_q, owen_d;
    logic [BE_WIDTH-1:0]   obe_q    [N_OUP];
    logic [BE_WIDTH-1:0]   obe_d    [N_OUP];
    logic [IDW-1:0]        oid_q    [N_OUP];
    logic [IDW-1:0]        oid_d    [N_OUP];

    // The register accepts a new winner when empty or when the slave drains it now.
    always_comb begin
        take   = '0;
        ovld_d = ovld_q;
        owen_d = owen_q;
        for (int j = 0; j < N_OUP; j++) begin
            oadd_d[j]   = oadd_q[j];
            owdata_d[j] = owdata_q[j];
            obe_d[j]    = obe_q[j];
            oid_d[j]    = oid_q[j];
            take[j]     = win_vld[j] && (!ovld_q[j] || bus.oup_gnt_i[j]);
            if (take[j]) begin
                ovld_d[j]   = 1'b1;
                oadd_d[j]   = win_add[j];
                owdata_d[j] = win_wdata[j];
                owen_d[j]   = win_wen[j];
                obe_d[j]    = win_be[j];
                oid_d[j]    = win_idx[j];
            end else if (bus.oup_gnt_i[j]) begin
                ovld_d[j] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) ovld_q <= '0;
        else       ovld_q <= ovld_d;
    end

    always_ff @(posedge clk_i) begin
        oadd_q   <= oadd_d;
        owdata_q <= owdata_d;
        owen_q   <= owen_d;
        obe_q    <= obe_d;
        oid_q    <= oid_d;
    end

    always_comb begin
        src_vld   = ovld_q;
        src_add   = oadd_q;
        src_wdata = owdata_q;
        src_wen   = owen_q;
        src_be    = obe_q;
        src_id    = oid_q;
    end
`else
    always_comb begin
        take      = win_vld & bus.oup_gnt_i;
        src_vld   = win_vld;
        src_add   = win_add;
        src_wdata = win_wdata;
        src_wen   = win_wen;
        src_be    = win_be;
        src_id    = win_idx;
    end
`endif

    always_comb begin
        bus.oup_req_o   = src_vld;
        bus.oup_wen_o   = src_wen;
        bus.oup_add_o   = '0;
        bus.oup_wdata_o = '0;
        bus.oup_be_o    = '0;
        bus.oup_id_o    = '0;
        for (int j = 0; j < N_OUP; j++) begin
            bus.oup_add_o[j*ADDR_WIDTH +: ADDR_WIDTH]   = src_add[j];
            bus.oup_wdata_o[j*DATA_WIDTH +: DATA_WIDTH] = src_wdata[j];
            bus.oup_be_o[j*BE_WIDTH +: BE_WIDTH]        = src_be[j];
            bus.oup_id_o[j*IDW +: IDW]                  = src_id[j];
        end
    end

    always_comb begin
        acc = '0;
        for (int j = 0; j < N_OUP; j++) begin
            if (take[j]) acc[win_idx[j]] = 1'b1;
        end
        bus.inp_gnt_o = acc;
    end

    // Lowest-index matching output wins the data mux; any second match is a collision.
    always_comb begin
        rsp                  = '0;
        bus.inp_r_rdata_o    = '0;
        bus.inp_r_opc_o      = '0;
        bus.resp_collision_o = 1'b0;
        for (int i = 0; i < N_INP; i++) begin
            for (int j = 0; j < N_OUP; j++) begin
                if (!rst_i && bus.oup_r_valid_i[j] &&
                    bus.oup_r_id_i[j*IDW +: IDW] == IDW'(i)) begin
                    if (rsp[i]) begin
                        bus.resp_collision_o = 1'b1;
                    end else begin
                        bus.inp_r_rdata_o[i*DATA_WIDTH +: DATA_WIDTH] =
                            bus.oup_r_rdata_i[j*DATA_WIDTH +: DATA_WIDTH];
                        bus.inp_r_opc_o[i] = bus.oup_r_opc_i[j];
                    end
                    rsp[i] = 1'b1;
                end
            end
        end
        bus.inp_r_valid_o = rsp;
    end

    // Stray responses at cnt==0 are dropped so the counter never wraps.
    always_comb begin
        for (int i = 0; i < N_INP; i++) begin
            cnt_d[i] = cnt_q[i];
            tgt_d[i] = tgt_q[i];
            if (rsp[i] && cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CW'(1);
            if (acc[i]) begin
                cnt_d[i] = cnt_d[i] + CW'(1);
                tgt_d[i] = sel[i];
            end
        end
        for (int j = 0; j < N_OUP; j++) begin
            rr_d[j] = take[j] ? IDW'((int'(win_idx[j]) + 1) % N_INP) : rr_q[j];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_INP; i++) begin
                cnt_q[i] <= '0;
                tgt_q[i] <= '0;
            end
            for (int j = 0; j < N_OUP; j++) begin
                rr_q[j] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            tgt_q <= tgt_d;
            rr_q  <= rr_d;
        end
    end
endmodule

// File: tb/tb_periph_xbar_ot.sv
// Bench for periph_xbar_ot: directed scenarios plus randomized traffic compared against a
// transaction-level model of per-input counters and per-output round-robin pointers.
module tb_periph_xbar_ot;
    localparam int N_INP = 9;
    localparam int N_OUP = 10;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int BW    = 4;
    localparam int MAXO  = 2;
    localparam int IDW   = 4;
    localparam int SELW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    periph_xbar_ot_if #(.N_INP(N_INP), .N_OUP(N_OUP), .ADDR_WIDTH(AW),
                        .DATA_WIDTH(DW), .BE_WIDTH(BW)) bus ();

    periph_xbar_ot #(.N_INP(N_INP), .N_OUP(N_OUP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                     .BE_WIDTH(BW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    int             m_cnt   [N_INP];
    int             m_tgt   [N_INP];
    int             m_rr    [N_OUP];
    int             sel_drv [N_INP];
    logic [AW-1:0]  add_drv [N_INP];
    logic [DW-1:0]  wd_drv  [N_INP];
    bit             rv_drv  [N_OUP];
    int             rid_drv [N_OUP];
    logic [DW-1:0]  rd_drv  [N_OUP];
    logic [N_INP-1:0] exp_gnt;
    logic [N_INP-1:0] exp_rv;
    logic [N_OUP-1:0] exp_oreq;
    int             exp_id  [N_OUP];
    logic [DW-1:0]  exp_rd  [N_INP];

    initial begin
        #400000;
        $display("FAIL watchdog timeout reached");
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int i, input bit r, input int s);
        bus.inp_req_i[i] = r;
        bus.inp_sel_i[i*SELW +: SELW] = SELW'(s);
        sel_drv[i] = s;
    endtask

    task automatic drive_rsp(input int j, input bit v, input int id, input logic [DW-1:0] d);
        bus.oup_r_valid_i[j] = v;
        bus.oup_r_id_i[j*IDW +: IDW] = IDW'(id);
        bus.oup_r_rdata_i[j*DW +: DW] = d;
        bus.oup_r_opc_i[j] = d[0];
        rv_drv[j]  = v;
        rid_drv[j] = id;
        rd_drv[j]  = d;
    endtask

    task automatic idle_all();
        bus.inp_add_i   = '0;
        bus.inp_wdata_i = '0;
        bus.inp_wen_i   = '1;
        bus.inp_be_i    = '0;
        bus.oup_gnt_i   = '0;
        for (int i = 0; i < N_INP; i++) begin
            drive_req(i, 1'b0, 0);
            add_drv[i] = '0;
            wd_drv[i]  = '0;
        end
        for (int j = 0; j < N_OUP; j++) drive_rsp(j, 1'b0, 0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_all();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < N_INP; i++) begin
            m_cnt[i] = 0;
            m_tgt[i] = 0;
        end
        for (int j = 0; j < N_OUP; j++) m_rr[j] = 0;
    endtask

    function automatic bit m_ok(input int i);
        int s;
        s = sel_drv[i];
        if (!bus.inp_req_i[i] || s >= N_OUP) return 1'b0;
        return (m_cnt[i] == 0) || (m_tgt[i] == s && m_cnt[i] < MAXO);
    endfunction

    // Expected outputs for the current cycle, derived from the model state and driven inputs.
    function automatic void m_eval();
        int i;
        exp_gnt  = '0;
        exp_oreq = '0;
        exp_rv   = '0;
        for (int j = 0; j < N_OUP; j++) begin
            exp_id[j] = 0;
            for (int k = 0; k < N_INP; k++) begin
                i = (m_rr[j] + k) % N_INP;
                if (m_ok(i) && sel_drv[i] == j) begin
                    exp_oreq[j] = 1'b1;
                    exp_id[j]   = i;
                    if (bus.oup_gnt_i[j]) exp_gnt[i] = 1'b1;
                    break;
                end
            end
        end
        for (int n = 0; n < N_INP; n++) exp_rd[n] = '0;
        for (int j = 0; j < N_OUP; j++) begin
            if (rv_drv[j] && rid_drv[j] < N_INP && !exp_rv[rid_drv[j]]) begin
                exp_rv[rid_drv[j]] = 1'b1;
                exp_rd[rid_drv[j]] = rd_drv[j];
            end
        end
    endfunction

    function automatic void m_commit();
        for (int i = 0; i < N_INP; i++) begin
            if (exp_rv[i] && m_cnt[i] > 0) m_cnt[i]--;
            if (exp_gnt[i]) begin
                m_cnt[i]++;
                m_tgt[i] = sel_drv[i];
            end
        end
        for (int j = 0; j < N_OUP; j++) begin
            if (exp_oreq[j] && bus.oup_gnt_i[j]) m_rr[j] = (exp_id[j] + 1) % N_INP;
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        idle_all();
        for (int i = 0; i < N_INP; i++) drive_req(i, 1'b1, 0);
        bus.oup_gnt_i = '1;
        drive_rsp(0, 1'b1, 0, 32'h1234);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus.oup_req_o !== '0 || bus.inp_gnt_o !== '0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d oup_req=%h inp_gnt=%h required 0/0",
                         c, bus.oup_req_o, bus.inp_gnt_o);
            end
            checks++;
            if (bus.inp_r_valid_o !== '0 || bus.resp_collision_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_rsp cyc %0d r_valid=%h coll=%b required 0/0",
                         c, bus.inp_r_valid_o, bus.resp_collision_o);
            end
            next_cycle();
        end
        rst = 1'b0;
        drive_rsp(0, 1'b0, 0, '0);
`ifdef PERIPH_XBAR_REQ_CUT_EN
        @(negedge clk);
        checks++;
        if (bus.inp_gnt_o !== N_INP'(1) || bus.oup_req_o !== '0) begin
            errors++;
            $display("FAIL reset_first_grant inp_gnt=%h oup_req=%h required %h/0",
                     bus.inp_gnt_o, bus.oup_req_o, N_INP'(1));
        end
        next_cycle();
`else
        bus.oup_gnt_i = '0;
        for (int j = 0; j < N_OUP; j++) begin
            for (int i = 0; i < N_INP; i++) drive_req(i, 1'b1, j);
            @(negedge clk);
            checks++;
            if (bus.oup_req_o !== (N_OUP'(1) << j) || bus.oup_id_o[j*IDW +: IDW] !== '0) begin
                errors++;
                $display("FAIL reset_first_winner out %0d oup_req=%h id=%0d required %h/0", j,
                         bus.oup_req_o, bus.oup_id_o[j*IDW +: IDW], N_OUP'(1) << j);
            end
            next_cycle();
        end
        for (int i = 0; i < N_INP; i++) drive_req(i, 1'b1, 3);
        bus.oup_gnt_i = '1;
        @(negedge clk);
        checks++;
        if (bus.inp_gnt_o !== N_INP'(1)) begin
            errors++;
            $display("FAIL reset_first_grant inp_gnt=%h required %h", bus.inp_gnt_o, N_INP'(1));
        end
        next_cycle();
`endif
        idle_all();
    endtask

`ifdef PERIPH_XBAR_REQ_CUT_EN
    task automatic test_cut_back_to_back();
        int seq [8] = '{0, 3, 0, 3, 0, 3, 0, 3};
        do_reset();
        drive_req(0, 1'b1, 2);
        drive_req(3, 1'b1, 2);
        bus.oup_gnt_i = '1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) drive_rsp(2, 1'b1, seq[k-1], DW'(32'hC000 + k));
            @(negedge clk);
            checks++;
            if (bus.inp_gnt_o !== (N_INP'(1) << seq[k])) begin
                errors++;
                $display("FAIL cut_gnt cyc %0d got %h required %h", k, bus.inp_gnt_o,
                         N_INP'(1) << seq[k]);
            end
            checks++;
            if (bus.oup_req_o[2] !== (k > 0) ||
                (k > 0 && bus.oup_id_o[2*IDW +: IDW] !== IDW'(seq[(k > 0) ? k-1 : 0]))) begin
                errors++;
                $display("FAIL cut_oup cyc %0d req=%b id=%0d required %b/%0d", k,
                         bus.oup_req_o[2], bus.oup_id_o[2*IDW +: IDW], (k > 0),
                         seq[(k > 0) ? k-1 : 0]);
            end
            next_cycle();
        end
        idle_all();
    endtask
`else
    task automatic test_round_robin();
        int seq [6] = '{0, 3, 5, 0, 3, 5};
        do_reset();
        drive_req(0, 1'b1, 2);
        drive_req(3, 1'b1, 2);
        drive_req(5, 1'b1, 2);
        bus.oup_gnt_i[2] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) drive_rsp(2, 1'b1, seq[k-1], DW'(32'hA000 + k));
            @(negedge clk);
            checks++;
            if (bus.inp_gnt_o !== (N_INP'(1) << seq[k]) ||
                bus.oup_id_o[2*IDW +: IDW] !== IDW'(seq[k])) begin
                errors++;
                $display("FAIL rr_order cyc %0d gnt=%h id=%0d required %h/%0d", k, bus.inp_gnt_o,
                         bus.oup_id_o[2*IDW +: IDW], N_INP'(1) << seq[k], seq[k]);
            end
            if (k > 0) begin
                checks++;
                if (bus.inp_r_valid_o !== (N_INP'(1) << seq[k-1]) ||
                    bus.inp_r_rdata_o[seq[k-1]*DW +: DW] !== DW'(32'hA000 + k)) begin
                    errors++;
                    $display("FAIL rr_resp cyc %0d r_valid=%h rdata=%h required %h/%h", k,
                             bus.inp_r_valid_o, bus.inp_r_rdata_o[seq[k-1]*DW +: DW],
                             N_INP'(1) << seq[k-1], 32'hA000 + k);
                end
            end
            next_cycle();
        end
        idle_all();
    endtask

    task automatic test_outstanding();
        bit expg [6] = '{1, 1, 0, 0, 0, 1};
        do_reset();
        drive_req(1, 1'b1, 4);
        bus.oup_gnt_i[4] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive_rsp(4, k == 4, 1, DW'(32'hB0 + k));
            @(negedge clk);
            checks++;
            if (bus.inp_gnt_o !== (expg[k] ? N_INP'(2) : N_INP'(0))) begin
                errors++;
                $display("FAIL outstanding cyc %0d gnt=%h required %h", k, bus.inp_gnt_o,
                         expg[k] ? N_INP'(2) : N_INP'(0));
            end
            next_cycle();
        end
        idle_all();
    endtask

    task automatic test_target_switch();
        bit expg [5] = '{1, 0, 0, 0, 1};
        do_reset();
        bus.oup_gnt_i = '1;
        for (int k = 0; k < 5; k++) begin
            drive_req(2, 1'b1, (k == 0) ? 3 : 6);
            drive_rsp(3, k == 3, 2, DW'(32'hD0 + k));
            @(negedge clk);
            checks++;
            if (bus.inp_gnt_o !== (expg[k] ? N_INP'(4) : N_INP'(0)) ||
                (k > 0 && bus.oup_req_o[6] !== expg[k])) begin
                errors++;
                $display("FAIL target_switch cyc %0d gnt=%h oup_req6=%b required %h/%b", k,
                         bus.inp_gnt_o, bus.oup_req_o[6], expg[k] ? N_INP'(4) : N_INP'(0),
                         expg[k]);
            end
            next_cycle();
        end
        idle_all();
    endtask

    task automatic test_simultaneous();
        bit expg [4] = '{1, 1, 1, 0};
        do_reset();
        drive_req(0, 1'b1, 1);
        bus.oup_gnt_i[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive_rsp(1, k == 1, 0, DW'(32'hE0 + k));
            @(negedge clk);
            checks++;
            if (bus.inp_gnt_o !== (expg[k] ? N_INP'(1) : N_INP'(0))) begin
                errors++;
                $display("FAIL simultaneous cyc %0d gnt=%h required %h", k, bus.inp_gnt_o,
                         expg[k] ? N_INP'(1) : N_INP'(0));
            end
            next_cycle();
        end
        idle_all();
    endtask

    task automatic test_random();
        int  cands[$];
        int  pick;
        bit  stray_used;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N_INP; i++) begin
                drive_req(i, $urandom_range(0, 2) != 0,
                          ($urandom_range(0, 19) == 0) ? N_OUP + $urandom_range(0, 5)
                                                       : $urandom_range(0, 3));
                add_drv[i] = $urandom;
                wd_drv[i]  = $urandom;
                bus.inp_add_i[i*AW +: AW]   = add_drv[i];
                bus.inp_wdata_i[i*DW +: DW] = wd_drv[i];
            end
            bus.oup_gnt_i = N_OUP'($urandom);
            stray_used = 1'b0;
            for (int j = 0; j < N_OUP; j++) begin
                cands.delete();
                for (int i = 0; i < N_INP; i++)
                    if (m_cnt[i] > 0 && m_tgt[i] == j) cands.push_back(i);
                if (cands.size() > 0 && $urandom_range(0, 1) == 1) begin
                    pick = cands[$urandom_range(0, cands.size() - 1)];
                    drive_rsp(j, 1'b1, pick, $urandom);
                end else begin
                    drive_rsp(j, 1'b0, 0, '0);
                    pick = $urandom_range(0, N_INP - 1);
                    if (!stray_used && m_cnt[pick] == 0 && !bus.inp_req_i[pick] &&
                        $urandom_range(0, 7) == 0) begin
                        drive_rsp(j, 1'b1, pick, $urandom);
                        stray_used = 1'b1;
                    end
                end
            end
            m_eval();
            @(negedge clk);
            checks++;
            if (bus.inp_gnt_o !== exp_gnt || bus.oup_req_o !== exp_oreq) begin
                errors++;
                $display("FAIL rand_handshake cyc %0d gnt=%h oup_req=%h required %h/%h", cyc,
                         bus.inp_gnt_o, bus.oup_req_o, exp_gnt, exp_oreq);
            end
            for (int j = 0; j < N_OUP; j++) begin
                if (exp_oreq[j]) begin
                    checks++;
                    if (bus.oup_id_o[j*IDW +: IDW] !== IDW'(exp_id[j]) ||
                        bus.oup_add_o[j*AW +: AW] !== add_drv[exp_id[j]] ||
                        bus.oup_wdata_o[j*DW +: DW] !== wd_drv[exp_id[j]]) begin
                        errors++;
                        $display("FAIL rand_payload cyc %0d out %0d id=%0d add=%h required %0d/%h",
                                 cyc, j, bus.oup_id_o[j*IDW +: IDW], bus.oup_add_o[j*AW +: AW],
                                 exp_id[j], add_drv[exp_id[j]]);
                    end
                end
            end
            checks++;
            if (bus.inp_r_valid_o !== exp_rv || bus.resp_collision_o !== 1'b0) begin
                errors++;
                $display("FAIL rand_resp_valid cyc %0d r_valid=%h coll=%b required %h/0", cyc,
                         bus.inp_r_valid_o, bus.resp_collision_o, exp_rv);
            end
            for (int i = 0; i < N_INP; i++) begin
                if (exp_rv[i]) begin
                    checks++;
                    if (bus.inp_r_rdata_o[i*DW +: DW] !== exp_rd[i] ||
                        bus.inp_r_opc_o[i] !== exp_rd[i][0]) begin
                        errors++;
                        $display("FAIL rand_rdata cyc %0d inp %0d rdata=%h opc=%b required %h/%b",
                                 cyc, i, bus.inp_r_rdata_o[i*DW +: DW], bus.inp_r_opc_o[i],
                                 exp_rd[i], exp_rd[i][0]);
                    end
                end
            end
            m_commit();
            next_cycle();
        end
        idle_all();
    endtask
`endif

    initial begin
        idle_all();
        test_reset();
`ifdef PERIPH_XBAR_REQ_CUT_EN
        test_cut_back_to_back();
`else
        test_round_robin();
        test_outstanding();
        test_target_switch();
        test_simultaneous();
        test_random();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
